parity_stream: RTL and testbench

Parametrised, pipelined parity generator/checker for a valid/ready word stream. Per word, it computes the expected parity bit in even or odd mode and flags mismatches against a received parity bit. Across a frame delimited by `i_last`, it accumulates parity, error and beat-count summaries. It also keeps a saturating error counter. It sits between a byte/word source (e.g. a deserialiser) and downstream consumers, replacing the fixed 4-bit combinational parity function.

---
 rtl/parity_stream.sv | 155 +++++++++++++++
 tb/tb_parity_stream.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_stream.sv
// Pipelined parity generator/checker for a valid/ready word stream, with
// per-frame parity/error/length summaries and a saturating error counter.
module parity_stream #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_parity,
  input  logic                 i_odd,
  input  logic                 i_last,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_parity,
  output logic                 o_err,
  output logic                 o_last,
  output logic                 o_frame_parity,
  output logic                 o_frame_err,
  output logic [LEN_WIDTH-1:0] o_frame_len,
  output logic [CNT_WIDTH-1:0] o_err_count,
  input  logic                 i_clr_count
);

  typedef enum logic {IDLE, IN_FRAME} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_acc_par, w_acc_par_nxt;
  logic                 r_acc_err, w_acc_err_nxt;
  logic [LEN_WIDTH-1:0] r_acc_len, w_acc_len_nxt;
  logic                 w_f_par, w_f_err;
  logic [LEN_WIDTH-1:0] w_f_len;

  logic                 r_valid, r_parity, r_err, r_last;
  logic [WIDTH-1:0]     r_data;
  logic                 r_frame_parity, r_frame_err;
  logic [LEN_WIDTH-1:0] r_frame_len;
  logic [CNT_WIDTH-1:0] r_err_count;

  logic                 w_accept, w_par, w_exp, w_err;
  logic [LEN_WIDTH-1:0] w_len_inc;

  assign o_ready   = !i_rst && (!r_valid || i_ready);
  assign w_accept  = i_valid && o_ready;
  assign w_par     = ^i_data;
  assign w_exp     = w_par ^ i_odd;
  assign w_err     = i_parity ^ w_exp;
  assign w_len_inc = (r_acc_len == '1) ? r_acc_len : r_acc_len + LEN_WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_acc_par <= 1'b0;
      r_acc_err <= 1'b0;
      r_acc_len <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc_par <= w_acc_par_nxt;
      r_acc_err <= w_acc_err_nxt;
      r_acc_len <= w_acc_len_nxt;
    end
  end

  // Frame summaries are zero except on the closing beat of a frame.
  always_comb begin
    w_state_nxt   = r_state;
    w_acc_par_nxt = r_acc_par;
    w_acc_err_nxt = r_acc_err;
    w_acc_len_nxt = r_acc_len;
    w_f_par       = 1'b0;
    w_f_err       = 1'b0;
    w_f_len       = '0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (i_last) begin
            w_f_par = w_par;
            w_f_err = w_err;
            w_f_len = LEN_WIDTH'(1);
          end else begin
            w_state_nxt   = IN_FRAME;
            w_acc_par_nxt = w_par;
            w_acc_err_nxt = w_err;
            w_acc_len_nxt = LEN_WIDTH'(1);
          end
        end
        IN_FRAME: begin
          if (i_last) begin
            w_state_nxt   = IDLE;
            w_f_par       = r_acc_par ^ w_par;
            w_f_err       = r_acc_err | w_err;
            w_f_len       = w_len_inc;
            w_acc_par_nxt = 1'b0;
            w_acc_err_nxt = 1'b0;
            w_acc_len_nxt = '0;
          end else begin
            w_acc_par_nxt = r_acc_par ^ w_par;
            w_acc_err_nxt = r_acc_err | w_err;
            w_acc_len_nxt = w_len_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid        <= 1'b0;
      r_data         <= '0;
      r_parity       <= 1'b0;
      r_err          <= 1'b0;
      r_last         <= 1'b0;
      r_frame_parity <= 1'b0;
      r_frame_err    <= 1'b0;
      r_frame_len    <= '0;
    end else if (w_accept) begin
      r_valid        <= 1'b1;
      r_data         <= i_data;
      r_parity       <= w_exp;
      r_err          <= w_err;
      r_last         <= i_last;
      r_frame_parity <= w_f_par;
      r_frame_err    <= w_f_err;
      r_frame_len    <= w_f_len;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err_count <= '0;
    end else if (i_clr_count) begin
      r_err_count <= (w_accept && w_err) ? CNT_WIDTH'(1) : '0;
    end else if (w_accept && w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + CNT_WIDTH'(1);
    end
  end

  assign o_valid        = r_valid;
  assign o_data         = r_data;
  assign o_parity       = r_parity;
  assign o_err          = r_err;
  assign o_last         = r_last;
  assign o_frame_parity = r_frame_parity;
  assign o_frame_err    = r_frame_err;
  assign o_frame_len    = r_frame_len;
  assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_parity_stream.sv
// Self-checking bench for parity_stream: a transaction-level model built from
// ones counts and integer frame tallies predicts every output each cycle.
module tb_parity_stream;

  localparam int W = 8;
  localparam int C = 2;
  localparam int L = 3;
  localparam int CMAX = (1 << C) - 1;
  localparam int LMAX = (1 << L) - 1;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
    logic         p;
    logic         e;
    logic         l;
    logic         fp;
    logic         fe;
    logic [L-1:0] fl;
    logic [C-1:0] cnt;
  } out_t;

  logic         clk;
  logic         i_rst, i_valid, i_parity, i_odd, i_last, i_ready, i_clr_count;
  logic [W-1:0] i_data;
  logic         o_ready, o_valid, o_parity, o_err, o_last, o_frame_parity, o_frame_err;
  logic [W-1:0] o_data;
  logic [L-1:0] o_frame_len;
  logic [C-1:0] o_err_count;

  int n_cmp  = 0;
  int n_fail = 0;

  out_t m_out;
  int   m_fones, m_flen, m_cnt;
  bit   m_ferr;

  parity_stream #(.WIDTH(W), .CNT_WIDTH(C), .LEN_WIDTH(L)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_parity(i_parity), .i_odd(i_odd), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_parity(o_parity),
    .o_err(o_err), .o_last(o_last), .o_frame_parity(o_frame_parity),
    .o_frame_err(o_frame_err), .o_frame_len(o_frame_len),
    .o_err_count(o_err_count), .i_clr_count(i_clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t dut_out();
    out_t o;
    o.v = o_valid; o.d = o_data; o.p = o_parity; o.e = o_err; o.l = o_last;
    o.fp = o_frame_parity; o.fe = o_frame_err; o.fl = o_frame_len; o.cnt = o_err_count;
    return o;
  endfunction

  task automatic model_reset();
    m_out = '0; m_fones = 0; m_flen = 0; m_cnt = 0; m_ferr = 0;
  endtask

  task automatic model_update(input bit acc, input logic [W-1:0] d, input bit p,
                              input bit odd, input bit last, input bit clr, input bit rdy);
    bit e, err;
    if (acc) begin
      e   = bit'($countones(d) % 2) ^ odd;
      err = (p != e);
      m_fones += $countones(d);
      m_flen  += 1;
      m_ferr  |= err;
      m_out.v = 1; m_out.d = d; m_out.p = e; m_out.e = err; m_out.l = last;
      if (last) begin
        m_out.fp = bit'(m_fones % 2);
        m_out.fe = m_ferr;
        m_out.fl = L'((m_flen > LMAX) ? LMAX : m_flen);
        m_fones = 0; m_flen = 0; m_ferr = 0;
      end else begin
        m_out.fp = 0; m_out.fe = 0; m_out.fl = '0;
      end
      if (clr) m_cnt = err ? 1 : 0;
      else     m_cnt = (m_cnt + int'(err) > CMAX) ? CMAX : m_cnt + int'(err);
    end else begin
      if (clr) m_cnt = 0;
      if (rdy) m_out.v = 0;
    end
    m_out.cnt = C'(m_cnt);
  endtask

  // Drives one cycle of stimulus and advances the model; leaves time at edge+2.
  task automatic drive(input bit v, input logic [W-1:0] d, input bit p, input bit odd,
                       input bit last, input bit clr, input bit rdy);
    bit acc;
    i_valid = v; i_data = d; i_parity = p; i_odd = odd; i_last = last;
    i_clr_count = clr; i_ready = rdy;
    #1;
    acc = v && o_ready;
    model_update(acc, d, p, odd, last, clr, rdy);
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    i_rst = 1; i_valid = 0; i_data = '0; i_parity = 0; i_odd = 0; i_last = 0;
    i_ready = 1; i_clr_count = 0;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL reset_outputs: got %h want %h", dut_out(), m_out); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    i_rst = 0; #1;
    n_cmp++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", o_ready); end
  endtask

  task automatic test_modes();
    logic [W-1:0] dv [4] = '{8'h0F, 8'h07, 8'h07, 8'h00};
    bit           od [4] = '{0, 0, 1, 1};
    bit           ee [4] = '{0, 1, 0, 1};
    bit           er [4] = '{0, 1, 0, 1};
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1, dv[i], 0, od[i], 1, 0, 1);
      n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL mode_word%0d: got %h want %h", i, dut_out(), m_out); end
      n_cmp++; if ({o_parity, o_err} !== {ee[i], er[i]}) begin n_fail++; $display("FAIL mode_pe%0d: got %b%b want %b%b", i, o_parity, o_err, ee[i], er[i]); end
      if (i == 1) begin
        n_cmp++; if (o_err_count !== 2'd1) begin n_fail++; $display("FAIL mode_count: got %0d want 1", o_err_count); end
      end
    end
    drive(0, '0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_frame();
    logic [W-1:0] dv [3] = '{8'h01, 8'h03, 8'h07};
    bit           pv [3] = '{1, 0, 1};
    for (int unsigned rep = 0; rep < 2; rep++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        drive(1, dv[i], pv[i] ^ ((rep == 1) && (i == 1)), 0, i == 2, 0, 1);
        n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL frame%0d_beat%0d: got %h want %h", rep, i, dut_out(), m_out); end
        n_cmp++; if (o_err !== ((rep == 1) && (i == 1))) begin n_fail++; $display("FAIL frame%0d_err%0d: got %b", rep, i, o_err); end
      end
      n_cmp++;
      if ({o_frame_parity, o_frame_err, o_frame_len} !== {1'b0, rep == 1, 3'd3}) begin
        n_fail++; $display("FAIL frame%0d_summary: got %b %b %0d want 0 %0d 3", rep, o_frame_parity, o_frame_err, o_frame_len, rep);
      end
    end
    drive(0, '0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    out_t snap;
    int   nv;
    drive(1, 8'hA5, 0, 0, 1, 0, 0);
    snap = dut_out();
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1, 8'h3C, 1, 1, 0, 0, 0);
      n_cmp++; if (dut_out() !== snap || snap !== m_out) begin n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i, dut_out(), m_out); end
      n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b want 0", i, o_ready); end
    end
    drive(1, 8'h3C, 1, 1, 0, 0, 1);
    n_cmp++; if (dut_out() !== m_out || o_data !== 8'h3C) begin n_fail++; $display("FAIL bp_release: got %h want %h", dut_out(), m_out); end
    drive(0, '0, 0, 0, 0, 0, 1);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single: got valid %b want 0", o_valid); end
    nv = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1, W'($urandom), 1'($urandom), 1'($urandom), i == 7, 0, 1);
      if (o_valid === 1'b1) nv++;
      n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL stream%0d: got %h want %h", i, dut_out(), m_out); end
    end
    n_cmp++; if (nv !== 8) begin n_fail++; $display("FAIL stream_rate: got %0d want 8", nv); end
    drive(0, '0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_count_sat();
    int exp_c [5] = '{1, 2, 3, 3, 3};
    drive(0, '0, 0, 0, 0, 1, 1);
    n_cmp++; if (o_err_count !== 2'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d want 0", o_err_count); end
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1, 8'h01, 0, 0, 1, 0, 1);
      n_cmp++; if (o_err_count !== C'(exp_c[i]) || dut_out() !== m_out) begin n_fail++; $display("FAIL cnt_step%0d: got %0d want %0d", i, o_err_count, exp_c[i]); end
    end
    drive(1, 8'h01, 0, 0, 1, 1, 1);
    n_cmp++; if (o_err_count !== 2'd1) begin n_fail++; $display("FAIL cnt_clr_err: got %0d want 1", o_err_count); end
  endtask

  task automatic test_len_sat();
    for (int unsigned i = 0; i < 10; i++) begin
      drive(1, W'($urandom), 1'($urandom), 0, i == 9, 0, 1);
      n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL len_beat%0d: got %h want %h", i, dut_out(), m_out); end
    end
    n_cmp++; if (o_frame_len !== 3'd7) begin n_fail++; $display("FAIL len_sat: got %0d want 7", o_frame_len); end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 7, W'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
      n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL rand%0d: got %h want %h", i, dut_out(), m_out); end
      n_cmp++; if (o_ready !== (!m_out.v || i_ready)) begin n_fail++; $display("FAIL rand_ready%0d: got %b", i, o_ready); end
    end
  endtask

  task automatic test_rst_midframe();
    drive(1, 8'h11, 0, 0, 0, 0, 1);
    drive(1, 8'h22, 0, 0, 0, 0, 1);
    i_rst = 1; #1;
    model_reset();
    n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL async_rst: got %h want %h", dut_out(), m_out); end
    n_cmp++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL async_rst_ready: got %b want 0", o_ready); end
    @(posedge clk); #2;
    i_rst = 0;
    drive(1, 8'h80, 1, 0, 1, 0, 1);
    n_cmp++; if (dut_out() !== m_out) begin n_fail++; $display("FAIL post_rst_word: got %h want %h", dut_out(), m_out); end
    n_cmp++; if ({o_frame_len, o_frame_parity} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL post_rst_frame: got len %0d par %b want 1 1", o_frame_len, o_frame_parity); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_frame();
    test_backpressure();
    test_count_sat();
    test_len_sat();
    test_random();
    test_rst_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
